// File: rtl/ds_dac_pkg.sv
// Shared constants and the saturation helper for the delta-sigma DAC modulator.
package ds_dac_pkg;

  localparam int unsigned SAMPLE_W_DEF = 16;
  localparam int unsigned GUARD_W_DEF  = 4;
  localparam int unsigned DIV_W_DEF    = 16;
  localparam int unsigned ACC_W        = SAMPLE_W_DEF + GUARD_W_DEF;
  localparam int unsigned MIDSCALE     = 1 << (SAMPLE_W_DEF - 1);
  localparam int          FB_POS       = int'(MIDSCALE);
  localparam int          FB_NEG       = -int'(MIDSCALE);

  // Clip a wide signed sum into the signed range of a w-bit accumulator.
  function automatic logic signed [63:0] sat_acc(input logic signed [63:0] x,
                                                 input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/ds_dac_mod_if.sv
// Control/sample/pin bundle between the NCO side and the delta-sigma modulator.
interface ds_dac_mod_if
  import ds_dac_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned DIV_W    = DIV_W_DEF
);
  logic                en;
  logic [DIV_W-1:0]    clk_div;
  logic                sample_stb;
  logic [SAMPLE_W-1:0] din;
  logic                sat_clr;
  logic                dout;
  logic                dout_n;
  logic                sat_flag;

  modport master (output en, clk_div, sample_stb, din, sat_clr,
                  input  dout, dout_n, sat_flag);
  modport slave  (input  en, clk_div, sample_stb, din, sat_clr,
                  output dout, dout_n, sat_flag);
endinterface

// File: rtl/ds_sat_integ.sv
// One saturating integrator stage: q <= sat(add_a + add_b - sub) when enabled.
module ds_sat_integ
  import ds_dac_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [WIDTH-1:0] add_a_i,
  input  logic signed [WIDTH-1:0] add_b_i,
  input  logic signed [WIDTH-1:0] sub_i,
  output logic signed [WIDTH-1:0] q_o,
  output logic signed [WIDTH-1:0] nxt_c_o,
  output logic                    clip_c_o
);

  logic signed [WIDTH-1:0] q_q;
  logic signed [WIDTH-1:0] q_d;
  logic signed [63:0]      sum_c;
  logic signed [63:0]      sat_c;

  // Sum is formed wide so the clip decision sees the true overflow.
  assign sum_c    = 64'(add_a_i) + 64'(add_b_i) - 64'(sub_i);
  assign sat_c    = sat_acc(sum_c, WIDTH);
  assign nxt_c_o  = WIDTH'(sat_c);
  assign clip_c_o = en_i & (sat_c != sum_c);
  assign q_o      = q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i)     q_d = '0;
    else if (en_i) q_d = nxt_c_o;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/ds_dac_mod.sv
// First/second-order delta-sigma modulator turning unsigned NCO samples into a
// registered differential 1-bit pin stream.
module ds_dac_mod
  import ds_dac_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned ORDER    = 2,
  parameter int unsigned GUARD_W  = GUARD_W_DEF,
  parameter int unsigned DIV_W    = DIV_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  ds_dac_mod_if.slave bus
);

  localparam int unsigned ACC_BITS = SAMPLE_W + GUARD_W;
  localparam int unsigned MSB      = SAMPLE_W - 1;
  localparam logic signed [ACC_BITS-1:0] FB_P = ACC_BITS'(64'sd1 <<< MSB);
  localparam logic signed [ACC_BITS-1:0] FB_N = -FB_P;
  localparam logic [SAMPLE_W-1:0] HOLD_RST = SAMPLE_W'(64'd1 << MSB);

  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [DIV_W-1:0]    presc_q, presc_d;
  logic                dout_q, dout_d;
  logic                dout_n_q;
  logic                sat_q, sat_d;

  logic                       tick_c;
  logic                       run_c;
  logic                       clr_c;
  logic                       clip_c;
  logic signed [ACC_BITS-1:0] xs_c;
  logic signed [ACC_BITS-1:0] fb_c;
  logic signed [ACC_BITS-1:0] q_fin_c;

  assign tick_c = (presc_q == bus.clk_div);
  assign run_c  = bus.en & tick_c;
  assign clr_c  = ~bus.en;
  // Offset-binary to two's complement: flip the MSB, then sign-extend.
  assign xs_c   = ACC_BITS'($signed({~hold_q[MSB], hold_q[MSB-1:0]}));
  assign fb_c   = dout_q ? FB_P : FB_N;

  if (ORDER == 2) begin : g_o2
    logic signed [ACC_BITS-1:0] i1_q, i1_n, i2_q, i2_n;
    logic                       c1, c2;
    ds_sat_integ #(.WIDTH(ACC_BITS)) u_i1 (
      .clk, .rst_n, .en_i(run_c), .clr_i(clr_c),
      .add_a_i(i1_q), .add_b_i(xs_c), .sub_i(fb_c),
      .q_o(i1_q), .nxt_c_o(i1_n), .clip_c_o(c1)
    );
    ds_sat_integ #(.WIDTH(ACC_BITS)) u_i2 (
      .clk, .rst_n, .en_i(run_c), .clr_i(clr_c),
      .add_a_i(i2_q), .add_b_i(i1_n), .sub_i(fb_c),
      .q_o(i2_q), .nxt_c_o(i2_n), .clip_c_o(c2)
    );
    assign q_fin_c = i2_n;
    assign clip_c  = c1 | c2;
  end else if (ORDER == 1) begin : g_o1
    logic signed [ACC_BITS-1:0] i1_q, i1_n;
    logic                       c1;
    ds_sat_integ #(.WIDTH(ACC_BITS)) u_i1 (
      .clk, .rst_n, .en_i(run_c), .clr_i(clr_c),
      .add_a_i(i1_q), .add_b_i(xs_c), .sub_i(fb_c),
      .q_o(i1_q), .nxt_c_o(i1_n), .clip_c_o(c1)
    );
    assign q_fin_c = i1_n;
    assign clip_c  = c1;
  end else begin : g_bad
    $error("ds_dac_mod: ORDER must be 1 or 2");
  end

  // Capture, prescaler, quantizer/idle toggle and sticky saturation flag.
  always_comb begin
    hold_d  = hold_q;
    presc_d = presc_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    if (bus.sample_stb) hold_d = bus.din;
    if (!bus.en) begin
      presc_d = '0;
      dout_d  = ~dout_q;
    end else if (tick_c) begin
      presc_d = '0;
      dout_d  = ~q_fin_c[ACC_BITS-1];
    end else begin
      presc_d = presc_q + DIV_W'(1);
    end
    if (clip_c)           sat_d = 1'b1;
    else if (bus.sat_clr) sat_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q   <= HOLD_RST;
      presc_q  <= '0;
      dout_q   <= 1'b0;
      dout_n_q <= 1'b1;
      sat_q    <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      presc_q  <= presc_d;
      dout_q   <= dout_d;
      dout_n_q <= ~dout_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_n   = dout_n_q;
  assign bus.sat_flag = sat_q;

endmodule
